// File: rtl/flag_stack.sv
// Flag save/restore LIFO for interrupt entry/return: pushes {N,Z,V,L,I},
// and on pop drives the saved word to IBUS[15:11] with a one-cycle nflagwe strobe.
module flag_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk4,
  input  logic          nreset,
  input  logic          push,
  input  logic          pop,
  input  logic          fn,
  input  logic          fz,
  input  logic          fv,
  input  logic          fl,
  input  logic          fi,
  output logic [4:0]    ibus_flags,
  output logic          ibus_oe,
  output logic          nflagwe,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, RESTORE} state_t;

  state_t        state_q, state_d;
  logic [4:0]    mem [DEPTH];
  logic [4:0]    cur;
  logic [CW-1:0] sp_d;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_en;
  logic          do_pop;
  logic          err_d;
  logic [4:0]    flags_d;
  logic          oe_d;
  logic          we_n_d;
  logic          is_empty;
  logic          is_full;

  assign cur      = {fn, fz, fv, fl, fi};
  assign is_empty = (count == '0);
  assign is_full  = (count == CW'(DEPTH));
  assign top_idx  = AW'(count - CW'(1));

  // Next-state and registered-output decode
  always_comb begin
    state_d = IDLE;
    sp_d    = count;
    wr_en   = 1'b0;
    wr_idx  = AW'(count);
    err_d   = err;
    flags_d = ibus_flags;
    oe_d    = 1'b0;
    we_n_d  = 1'b1;
    do_pop  = pop && (state_q == IDLE) && !is_empty;

    if (pop && !do_pop) begin
      err_d = 1'b1;
    end

    if (do_pop) begin
      flags_d = mem[top_idx];
      oe_d    = 1'b1;
      we_n_d  = 1'b0;
      state_d = RESTORE;
      // Swap: restore the top entry, then overwrite it with the current flags
      if (push) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else begin
        sp_d = count - CW'(1);
      end
    end else if (push) begin
      if (is_full) begin
        err_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk4) begin
    if (nreset) begin
      state_q    <= IDLE;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      err        <= 1'b0;
      ibus_flags <= '0;
      ibus_oe    <= 1'b0;
      nflagwe    <= 1'b1;
    end else begin
      state_q    <= state_d;
      count      <= sp_d;
      empty      <= (sp_d == '0);
      full       <= (sp_d == CW'(DEPTH));
      err        <= err_d;
      ibus_flags <= flags_d;
      ibus_oe    <= oe_d;
      nflagwe    <= we_n_d;
    end
  end

  // Storage has no reset; contents are meaningless while sp is 0
  always_ff @(posedge clk4) begin
    if (!nreset && wr_en) begin
      mem[wr_idx] <= cur;
    end
  end

endmodule

// File: doc/flag_stack.md
# flag_stack

Hardware flag save/restore stack feeding the flag registers (including the overflow flag register) during interrupt entry and return. On a push it captures the current N, Z, V, L, I flags into a LIFO. On a pop it drives the saved word onto IBUS[15:11] and issues a one-cycle active-low flag write strobe, so each flag register reloads from its IBUS bit (V from IBUS13) on the next clk4 rising edge. Sits between the microcode control outputs and the flag registers' bus/write-enable inputs.

## Interface
Parameters:
- DEPTH, 4: number of stack entries, 2..8.
- CW, 3: width of the occupancy count, ≥ clog2(DEPTH+1).

Ports:
- clk4  in  1  system clock; all state changes on its rising edge.
- nreset  in  1  reset, synchronous, active-high.
- push  in  1  save the current flags this cycle.
- pop  in  1  restore the top entry.
- fn, fz, fv, fl, fi  in  1 each  current flag values.
- ibus_flags  out  5  {N,Z,V,L,I} for IBUS[15:11]; V maps to IBUS13.
- ibus_oe  out  1  high while ibus_flags must be driven onto IBUS.
- nflagwe  out  1  active-low flag write strobe to the flag registers.
- count  out  CW  number of occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- err  out  1  sticky; set on overflow, underflow or illegal pop.

## Operation
- Storage: DEPTH × 5-bit entries plus stack pointer sp, where sp == count. Entry packing is {fn,fz,fv,fl,fi}, MSB first.
- FSM states are IDLE and RESTORE.
- IDLE, pop only, not empty:
  - sp decrements.
  - ibus_flags ← entry[sp-1].
  - ibus_oe becomes 1 and nflagwe becomes 0, both registered.
  - Next state is RESTORE.
- RESTORE lasts exactly one cycle:
  - On the next edge, ibus_oe becomes 0, nflagwe becomes 1, and the FSM returns to IDLE.
  - ibus_flags holds its value.
- push only, not full: entry[sp] ← current flags, sp increments. Legal in either state.
- push when full: entry is dropped, sp is unchanged, err is set.
- pop when empty: no strobe, sp is unchanged, err is set.
- pop in RESTORE: ignored and err is set. A push in the same cycle is still processed.
- push and pop together in IDLE, not empty (swap):
  - The top entry is restored exactly as a pop.
  - entry[sp-1] is then overwritten with the current flags.
  - sp is unchanged; full does not matter.
- push and pop together when empty: the push is performed, the pop is an underflow and sets err.
- Reset:
  - sp = 0, state IDLE.
  - ibus_flags = 0, ibus_oe = 0, nflagwe = 1, err = 0, count = 0, empty = 1, full = 0.
  - Storage contents are don't-care.
  - Reset during RESTORE aborts it: nflagwe returns high on the reset edge.
- err clears only on reset.

## Timing
- Pop sampled at edge k:
  - At k+0 (registered): ibus_oe = 1, nflagwe = 0, ibus_flags valid.
  - At k+1: the flag registers sample IBUS with nflagwe low; the stack deasserts ibus_oe/nflagwe on that same edge.
  - nflagwe is therefore low for exactly one clk4 period.
- nflagwe and ibus_oe are glitch-free register outputs. ibus_flags is stable for the whole low period of nflagwe.
- count, empty and full update on the edge that samples push/pop.
- Back-to-back pops: a pop at k+1 (during RESTORE) is illegal. The minimum pop spacing is 2 cycles.
- No combinational path from any input to any output.

## Test plan
- Reset then idle: nreset=1 for 1 cycle → count=0, empty=1, full=0, nflagwe=1, ibus_oe=0, err=0.
- Push {N,Z,V,L,I}=10100, then pop 2 cycles later → ibus_flags=10100 (V=1 on IBUS13), nflagwe low for exactly 1 cycle, count returns to 0.
- Push 5 distinct words with DEPTH=4 → full=1 after the 4th, err=1 after the 5th. Four spaced pops return words 4,3,2,1 in order.
- Pop on empty → no nflagwe pulse, err=1. Pop during RESTORE → second pulse suppressed, err=1, count decremented only once.
- Swap with entry 01010 on top, current flags 11001, push and pop together → ibus_flags=01010, count unchanged; a later pop returns 11001.
- Reset asserted during RESTORE → nflagwe=1 and ibus_oe=0 on that edge, count=0.
